// File: rtl/wtm_arb_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
package wtm_arb_pkg;

    localparam int unsigned PROD_W = 8;
    localparam int unsigned OPND_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request scanning upward from ptr+1, wrapping at NREQ.
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    always_comb begin
        int unsigned k;
        k       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            k = (int'(i_ptr) + off) % NREQ;
            if (!o_any && i_req[ID_W'(k)]) begin
                o_any            = 1'b1;
                o_idx            = ID_W'(k);
                o_grant[ID_W'(k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wallace_tree_multiplier.sv
// 4-bit signed x 4-bit unsigned multiplier; partial products reduced by carry-save adders.
module wallace_tree_multiplier
    import wtm_arb_pkg::*;
(
    input  logic [OPND_W-1:0] i_a,
    input  logic [OPND_W-1:0] i_b,
    output logic [PROD_W-1:0] o_z
);

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_pp [OPND_W];
    logic [PROD_W-1:0] w_s1, w_c1, w_s2, w_c2;

    // Sign-extending A up front keeps every row correct modulo 2^8.
    assign w_a_ext = {{(PROD_W - OPND_W){i_a[OPND_W-1]}}, i_a};

    always_comb begin
        for (int j = 0; j < int'(OPND_W); j++) begin
            w_pp[j] = i_b[j] ? (w_a_ext << j) : '0;
        end
    end

    assign w_s1 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
    assign w_c1 = ((w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2])) << 1;
    assign w_s2 = w_s1 ^ w_c1 ^ w_pp[3];
    assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp[3]) | (w_c1 & w_pp[3])) << 1;
    assign o_z  = w_s2 + w_c2;

endmodule

// File: rtl/wtm_mul_arbiter.sv
// Shares one multiplier among NREQ requesters: RR grant, timed multiply, valid/ready response.
module wtm_mul_arbiter
    import wtm_arb_pkg::*;
#(
    parameter  int unsigned NREQ     = 4,
    parameter  int unsigned MUL_WAIT = 1,
    localparam int unsigned ID_W     = $clog2(NREQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ*OPND_W-1:0] i_req_a,
    input  logic [NREQ*OPND_W-1:0] i_req_b,
    output logic [NREQ-1:0]        o_req_ready,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic [PROD_W-1:0]      o_rsp_z,
    output logic                   o_busy
);

    localparam int unsigned CNT_W = 4;

    state_e            r_state, w_state_next;
    logic [ID_W-1:0]   r_ptr, r_id, r_rsp_id;
    logic [CNT_W-1:0]  r_cnt;
    logic [OPND_W-1:0] r_a, r_b;
    logic              r_rsp_valid;
    logic [PROD_W-1:0] r_rsp_z;
    logic [PROD_W-1:0] w_prod;
    logic [NREQ-1:0]   w_grant;
    logic [ID_W-1:0]   w_win;
    logic              w_any;
    logic              w_fire;
    logic              w_capture;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win),
        .o_any   (w_any)
    );

    wallace_tree_multiplier u_mul (
        .i_a (r_a),
        .i_b (r_b),
        .o_z (w_prod)
    );

    always_comb begin
        w_state_next = r_state;
        o_req_ready  = '0;
        w_fire       = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    o_req_ready  = w_grant;
                    w_fire       = 1'b1;
                    w_state_next = MUL;
                end
            end
            MUL: begin
                if (r_cnt == CNT_W'(MUL_WAIT - 1)) begin
                    w_capture    = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr       <= ID_W'(NREQ - 1);
            r_id        <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_z     <= '0;
        end else begin
            if (w_fire) begin
                r_a   <= i_req_a[w_win*OPND_W +: OPND_W];
                r_b   <= i_req_b[w_win*OPND_W +: OPND_W];
                r_id  <= w_win;
                r_ptr <= w_win;
                r_cnt <= '0;
            end
            if (r_state == MUL) r_cnt <= r_cnt + 1'b1;
            if (w_capture) begin
                r_rsp_z     <= w_prod;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == RESP && i_rsp_ready) r_rsp_valid <= 1'b0;
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_z     = r_rsp_z;
    assign o_busy      = (r_state != IDLE);

endmodule
